// File: rtl/adat_i_deframe_pp_buf_pkg.sv
// Shared ADAT frame geometry, read-word field positions and a constant clog2.
package adat_i_deframe_pp_buf_pkg;
   localparam int GRPS_PER_FRAME = 49;
   localparam int GRPS_PER_CHAN  = 6;
   localparam int CHANS          = 8;
   localparam int USER_GRP       = 0;

   localparam int ERR_BIT    = 31;
   localparam int USER_LSB   = 24;
   localparam int SAMPLE_MSB = 23;

   localparam logic [5:0] IDX_IDLE = 6'd63;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
endpackage

// File: rtl/adat_i_deframe_pp_buf_bank.sv
// Per-stream ping-pong store: 2 banks x 8 words of {err, sample[23:0]}.
module adat_i_pp_bank (
   input  logic        clk,
   input  logic        reset,
   input  logic        wr_en,
   input  logic        wr_bank,
   input  logic [2:0]  wr_addr,
   input  logic [24:0] wr_data,
   input  logic        rd_en,
   input  logic        rd_bank,
   input  logic [2:0]  rd_addr,
   output logic [24:0] rd_data
);
   logic [24:0] mem [16];

   always_ff @(posedge clk)
      if (wr_en) mem[{wr_bank, wr_addr}] <= wr_data;

   // Storage is not reset; only the read register is.
   always_ff @(posedge clk)
      if (reset)      rd_data <= '0;
      else if (rd_en) rd_data <= mem[{rd_bank, rd_addr}];
endmodule

// File: rtl/adat_i_deframe_pp_buf.sv
// ADAT input deframer: marker check, sample assembly, ping-pong buffering and read port.
module adat_i_deframe_pp_buf
   import adat_i_deframe_pp_buf_pkg::*;
#(
   parameter int STREAMS     = 1,
   parameter int SAMPLE_BITS = 24,
   parameter int ERR_CNT_W   = 8,
   localparam int SW     = (clog2(STREAMS) > 1) ? clog2(STREAMS) : 1,
   localparam int ADDR_W = SW + 3
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [STREAMS*5-1:0]   grp_data,
   input  logic                   grp_valid,
   input  logic                   frame_start,
   input  logic                   rd_en,
   input  logic [ADDR_W-1:0]      rd_addr,
   output logic [31:0]            rd_data,
   output logic                   rd_valid,
   output logic                   frame_ready,
   output logic [STREAMS*4-1:0]   user_bits,
   output logic [ERR_CNT_W-1:0]   short_frame_cnt,
   output logic [ERR_CNT_W-1:0]   marker_err_cnt
);
   localparam logic [5:0]  LAST_IDX = 6'(GRPS_PER_FRAME - 1);
   localparam logic [2:0]  LAST_POS = 3'(GRPS_PER_CHAN - 1);
   localparam logic [2:0]  LAST_CH  = 3'(CHANS - 1);
   localparam logic [23:0] SMASK    = ~(24'hFFFFFF >> SAMPLE_BITS);

   logic [5:0] grp_idx;
   logic [2:0] ch, pos;   // slot of the next data group
   logic       bank_sel;  // write bank; read bank is its complement
   logic       have_frame;

   logic is_user, is_data, wr_now, done, short_hit, user_bad;
   logic [STREAMS-1:0]         markers, err_vec;
   logic [STREAMS*4-1:0]       user_w;
   logic [STREAMS-1:0][24:0]   bank_q;

   assign is_user   = grp_valid & frame_start;
   assign is_data   = grp_valid & ~frame_start & (grp_idx < LAST_IDX);
   assign wr_now    = is_data & (pos == LAST_POS);
   assign done      = wr_now & (ch == LAST_CH);
   assign short_hit = is_user & (grp_idx < LAST_IDX);
   assign user_bad  = is_user & ~(&markers);

   always_ff @(posedge clk)
      if (reset) begin
         grp_idx <= IDX_IDLE;
         pos     <= '0;
         ch      <= '0;
      end else if (is_user) begin
         grp_idx <= 6'(USER_GRP);
         pos     <= '0;
         ch      <= '0;
      end else if (is_data) begin
         grp_idx <= grp_idx + 6'd1;
         pos     <= (pos == LAST_POS) ? 3'd0 : pos + 3'd1;
         if (pos == LAST_POS) ch <= ch + 3'd1;
      end

   for (genvar s = 0; s < STREAMS; s++) begin : g_stream
      logic [23:0] acc, full;
      logic [3:0]  nib;
      logic        err, err_now;
      logic [24:0] word;

      assign markers[s] = grp_data[5*s+4];
      assign nib        = grp_data[5*s+3 -: 4];
      assign full       = {acc[19:0], nib};
      assign err_now    = ((pos != 3'd0) & err) | ~markers[s];
      assign word       = err_now ? {1'b1, 24'd0} : {1'b0, full & SMASK};
      assign err_vec[s] = wr_now & err_now;

      always_ff @(posedge clk)
         if (reset) begin
            acc <= '0;
            err <= 1'b0;
            user_w[4*s +: 4] <= '0;
         end else begin
            if (is_data) begin
               acc <= full;
               err <= err_now;
            end
            if (is_user) user_w[4*s +: 4] <= markers[s] ? nib : 4'd0;
         end

      adat_i_pp_bank u_bank (
         .clk     (clk),
         .reset   (reset),
         .wr_en   (wr_now),
         .wr_bank (bank_sel),
         .wr_addr (ch),
         .wr_data (word),
         .rd_en   (rd_en),
         .rd_bank (~bank_sel),
         .rd_addr (rd_addr[2:0]),
         .rd_data (bank_q[s])
      );
   end

   // Error counter may take several increments in one cycle; clamp instead of wrapping.
   logic [4:0]           err_inc;
   logic [ERR_CNT_W+4:0] err_sum;
   assign err_inc = 5'($countones(err_vec)) + {4'd0, user_bad};
   assign err_sum = {5'd0, marker_err_cnt} + {{ERR_CNT_W{1'b0}}, err_inc};

   always_ff @(posedge clk)
      if (reset) begin
         bank_sel        <= 1'b0;
         have_frame      <= 1'b0;
         frame_ready     <= 1'b0;
         user_bits       <= '0;
         short_frame_cnt <= '0;
         marker_err_cnt  <= '0;
      end else begin
         frame_ready <= done;
         if (done) begin
            bank_sel   <= ~bank_sel;
            have_frame <= 1'b1;
            user_bits  <= user_w;
         end
         if (short_hit && !(&short_frame_cnt)) short_frame_cnt <= short_frame_cnt + 1'b1;
         if (err_sum[ERR_CNT_W+4:ERR_CNT_W] != '0) marker_err_cnt <= '1;
         else                                       marker_err_cnt <= err_sum[ERR_CNT_W-1:0];
      end

   // Read side: everything feeding rd_data is captured on rd_en so it holds while idle.
   logic [SW-1:0] rd_stream, rs_q;
   logic          oob, oob_q;
   logic [3:0]    usr_sel, usr_q;
   logic [24:0]   bq_sel;

   assign rd_stream = rd_addr[ADDR_W-1:3];
   assign oob       = (int'(rd_stream) >= STREAMS);

   always_comb begin
      usr_sel = '0;
      bq_sel  = '0;
      for (int s = 0; s < STREAMS; s++) begin
         if (int'(rd_stream) == s) usr_sel = user_bits[4*s +: 4];
         if (int'(rs_q) == s)      bq_sel  = bank_q[s];
      end
   end

   always_ff @(posedge clk)
      if (reset) begin
         rd_valid <= 1'b0;
         rs_q     <= '0;
         oob_q    <= 1'b0;
         usr_q    <= '0;
      end else begin
         rd_valid <= rd_en & have_frame;
         if (rd_en) begin
            rs_q  <= rd_stream;
            oob_q <= oob;
            usr_q <= usr_sel;
         end
      end

   always_comb begin
      rd_data = '0;
      if (!oob_q) begin
         rd_data[ERR_BIT]          = bq_sel[24];
         rd_data[USER_LSB +: 4]    = usr_q;
         rd_data[SAMPLE_MSB:0]     = bq_sel[23:0];
      end
   end
endmodule

// File: tb/tb_adat_i_deframe_pp_buf.sv
// Directed bench: 2-stream/24-bit main instance plus a 3-stream/16-bit instance on shared stimulus.
module tb_adat_i_deframe_pp_buf;
   logic        clk = 1'b0;
   logic        reset, grp_valid, frame_start, rd_en;
   logic [9:0]  grp_data;
   logic [14:0] grp_data16;
   logic [3:0]  rd_addr;
   logic [4:0]  rd_addr16;

   logic [31:0] rd_data, rd_data16;
   logic        rd_valid, rd_valid16, frame_ready, frame_ready16;
   logic [7:0]  user_bits, short_cnt, merr_cnt, short_cnt16, merr_cnt16;
   logic [11:0] user_bits16;

   int errors = 0, checks = 0, fr_cnt = 0, fr_base;
   logic [23:0] smp [2][8];
   logic [3:0]  usr [2];
   logic        bad_en;
   int          bad_s, bad_ch, bad_pos;
   logic [31:0] got_d;
   logic        got_v, got_d16_v;
   logic [31:0] got_d16;

   always #5 clk = ~clk;
   always @(posedge clk) if (frame_ready) fr_cnt <= fr_cnt + 1;

   adat_i_deframe_pp_buf #(.STREAMS(2), .SAMPLE_BITS(24), .ERR_CNT_W(8)) dut (
      .clk(clk), .reset(reset), .grp_data(grp_data), .grp_valid(grp_valid),
      .frame_start(frame_start), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .rd_valid(rd_valid), .frame_ready(frame_ready), .user_bits(user_bits),
      .short_frame_cnt(short_cnt), .marker_err_cnt(merr_cnt));

   adat_i_deframe_pp_buf #(.STREAMS(3), .SAMPLE_BITS(16), .ERR_CNT_W(8)) dut16 (
      .clk(clk), .reset(reset), .grp_data(grp_data16), .grp_valid(grp_valid),
      .frame_start(frame_start), .rd_en(rd_en), .rd_addr(rd_addr16), .rd_data(rd_data16),
      .rd_valid(rd_valid16), .frame_ready(frame_ready16), .user_bits(user_bits16),
      .short_frame_cnt(short_cnt16), .marker_err_cnt(merr_cnt16));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Sends groups 0..n-1 of a frame; returns #1 after the edge taking the last group.
   task automatic send_frame(input int n);
      logic [23:0] w;
      for (int idx = 0; idx < n; idx++) begin
         for (int s = 0; s < 2; s++) begin
            if (idx == 0) begin
               grp_data[5*s +: 5] = {1'b1, usr[s]};
            end else begin
               w = smp[s][(idx-1)/6];
               grp_data[5*s +: 5] = {1'b1, w[20-4*((idx-1)%6) +: 4]};
               if (bad_en && s == bad_s && (idx-1)/6 == bad_ch && (idx-1)%6 == bad_pos)
                  grp_data[5*s+4] = 1'b0;
            end
         end
         grp_data16  = {5'b10000, grp_data};
         grp_valid   = 1'b1;
         frame_start = (idx == 0);
         @(posedge clk); #1;
      end
      grp_valid   = 1'b0;
      frame_start = 1'b0;
   endtask

   task automatic do_read(input logic [4:0] a);
      rd_en     = 1'b1;
      rd_addr   = a[3:0];
      rd_addr16 = a;
      @(posedge clk); #1;
      rd_en     = 1'b0;
      got_d     = rd_data;
      got_v     = rd_valid;
      got_d16   = rd_data16;
      got_d16_v = rd_valid16;
   endtask

   initial begin
      reset = 1'b1; grp_valid = 1'b0; frame_start = 1'b0; rd_en = 1'b0;
      grp_data = '0; grp_data16 = '0; rd_addr = '0; rd_addr16 = '0; bad_en = 1'b0;
      bad_s = 0; bad_ch = 0; bad_pos = 0;
      for (int s = 0; s < 2; s++)
         for (int c = 0; c < 8; c++) smp[s][c] = 24'hA0005C | (24'(s) << 16) | (24'(c) << 8);
      smp[0][3] = 24'h123456;
      smp[1][0] = 24'hABCDEF;
      usr[0] = 4'hA; usr[1] = 4'h5;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_rd_data", rd_data, 32'd0);
      chk("rst_frame_ready", 32'(frame_ready), 32'd0);
      chk("rst_user_bits", 32'(user_bits), 32'd0);
      chk("rst_counters", {short_cnt, merr_cnt}, 32'd0);
      do_read(5'h03);
      chk("read_before_frame_valid", 32'(got_v), 32'd0);

      // frame 1: clean
      fr_base = fr_cnt;
      send_frame(49);
      chk("f1_frame_ready", 32'(frame_ready), 32'd1);
      chk("f1_user_bits", 32'(user_bits), 32'h5A);
      @(posedge clk); #1;
      chk("f1_ready_pulse_width", 32'(frame_ready), 32'd0);
      chk("f1_ready_count", 32'(fr_cnt - fr_base), 32'd1);
      do_read(5'h03);
      chk("f1_s0c3_valid", 32'(got_v), 32'd1);
      chk("f1_s0c3", got_d, 32'h0A123456);
      chk("f1_s0c3_16b", got_d16, 32'h0A123400);
      @(posedge clk); #1;
      chk("hold_valid_low", 32'(rd_valid), 32'd0);
      chk("hold_data", rd_data, 32'h0A123456);
      do_read(5'h0A);
      chk("f1_s1c2", got_d, 32'h05A1025C);
      do_read(5'h08);
      chk("f1_s1c0_24b", got_d, 32'h05ABCDEF);
      chk("f1_s1c0_16b", got_d16, 32'h05ABCD00);
      do_read(5'h18);
      chk("oob_valid", 32'(got_d16_v), 32'd1);
      chk("oob_data", got_d16, 32'd0);
      chk("f1_merr", 32'(merr_cnt), 32'd0);

      // frame 2: stream1 ch5, 2nd group marker bad
      bad_en = 1'b1; bad_s = 1; bad_ch = 5; bad_pos = 1;
      fr_base = fr_cnt;
      send_frame(49);
      bad_en = 1'b0;
      @(posedge clk); #1;
      chk("f2_ready_count", 32'(fr_cnt - fr_base), 32'd1);
      chk("f2_merr", 32'(merr_cnt), 32'd1);
      do_read(5'h0D);
      chk("f2_s1c5_err", got_d, 32'h85000000);
      do_read(5'h0C);
      chk("f2_s1c4_clean", got_d, 32'h05A1045C);

      // short frame aborted at grp_idx 30
      smp[0][3] = 24'h654321; usr[0] = 4'h3;
      fr_base = fr_cnt;
      send_frame(31);
      @(posedge clk); #1;
      chk("short_no_ready", 32'(fr_cnt - fr_base), 32'd0);
      do_read(5'h03);
      chk("short_old_bank", got_d, 32'h0A123456);
      send_frame(49);
      @(posedge clk); #1;
      chk("short_cnt_1", 32'(short_cnt), 32'd1);
      chk("after_short_ready", 32'(fr_cnt - fr_base), 32'd1);
      chk("after_short_user", 32'(user_bits), 32'h53);
      do_read(5'h03);
      chk("after_short_s0c3", got_d, 32'h03654321);

      // user group only, then new frame
      send_frame(1);
      send_frame(49);
      chk("short_cnt_user_only", 32'(short_cnt), 32'd2);

      // saturation
      for (int i = 0; i < 300; i++) send_frame(2);
      chk("short_cnt_sat", 32'(short_cnt), 32'd255);
      send_frame(49);
      chk("short_cnt_no_wrap", 32'(short_cnt), 32'd255);
      chk("merr_unchanged", 32'(merr_cnt), 32'd1);

      // reset mid-frame
      send_frame(20);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      chk("mid_rst_counters", {short_cnt, merr_cnt}, 32'd0);
      chk("mid_rst_user_bits", 32'(user_bits), 32'd0);
      do_read(5'h03);
      chk("mid_rst_rd_valid", 32'(got_v), 32'd0);
      fr_base = fr_cnt;
      send_frame(49);
      @(posedge clk); #1;
      chk("mid_rst_ready_count", 32'(fr_cnt - fr_base), 32'd1);
      do_read(5'h03);
      chk("mid_rst_valid", 32'(got_v), 32'd1);
      chk("mid_rst_data", got_d, 32'h03654321);
      chk("mid_rst_counters_after", {short_cnt, merr_cnt}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
